// File: rtl/multiplicador_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// Optional early termination is selected with the MULT_EARLY_EXIT_EN macro.
package multiplicador_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Enough bits to hold the iteration count, including the final value WIDTH
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/mult_shift_add_dp.sv
// Datapath of the shift-and-add multiplier: operand shifters, accumulator, iteration counter.
// Its status outputs feed the MULT_EARLY_EXIT_EN decision in the top level.
import multiplicador_pkg::*;

module mult_shift_add_dp #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   operando_a,
  input  logic [WIDTH-1:0]   operando_b,
  output logic [2*WIDTH-1:0] acc,
  output logic               b_zero,
  output logic               count_full
);

  localparam int CW = cnt_width(WIDTH);

  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [CW-1:0]      count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      a_reg <= {{WIDTH{1'b0}}, operando_a};
      b_reg <= operando_b;
      acc   <= '0;
      count <= '0;
    end else if (step) begin
      // acc never exceeds a*b < 2^(2*WIDTH), so the add cannot overflow
      if (b_reg[0]) begin
        acc <= acc + a_reg;
      end
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
      count <= count + 1'b1;
    end
  end

  assign b_zero     = (b_reg == '0);
  assign count_full = (count == CW'(WIDTH));

endmodule

// File: rtl/multiplicador.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one multiplier bit per clock.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
import multiplicador_pkg::*;

module multiplicador #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iniciar,
  input  logic [WIDTH-1:0]   operando_a,
  input  logic [WIDTH-1:0]   operando_b,
  output logic [2*WIDTH-1:0] producto,
  output logic               terminado
);

  state_t             state;
  logic               load;
  logic               step;
  logic               finish;
  logic [2*WIDTH-1:0] acc;
  logic               b_zero;
  logic               count_full;

`ifdef MULT_EARLY_EXIT_EN
  assign finish = count_full || b_zero;
`else
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
  assign finish        = count_full;
`endif

  // A start is accepted from IDLE and from DONE, never while BUSY
  assign load = (state != BUSY) && iniciar;
  assign step = (state == BUSY) && !finish;

  mult_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .operando_a(operando_a),
    .operando_b(operando_b),
    .acc       (acc),
    .b_zero    (b_zero),
    .count_full(count_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      producto  <= '0;
      terminado <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (iniciar) begin
            terminado <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            producto  <= acc;
            terminado <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador.sv
// Self-checking bench for multiplicador against an arithmetic reference model.
// Expected latency follows MULT_EARLY_EXIT_EN when that macro is defined.
module tb_multiplicador;

  logic        clk;
  logic        rst_n;
  logic        iniciar;
  logic [15:0] operando_a;
  logic [15:0] operando_b;
  logic [31:0] producto;
  logic        terminado;

  int nChecks = 0;
  int nFails  = 0;

  multiplicador dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iniciar   (iniciar),
    .operando_a(operando_a),
    .operando_b(operando_b),
    .producto  (producto),
    .terminado (terminado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: edges from the start sample until terminado is seen high
  function automatic int refLatency(input logic [15:0] b);
`ifdef MULT_EARLY_EXIT_EN
    int top;
    if (b == 16'd0) return 1;
    top = 0;
    for (int i = 0; i < 16; i++) if (b[i]) top = i;
    return top + 2;
`else
    return 17;
`endif
  endfunction

  // Issues a start held for 'hold' sampled edges; returns observed latency and product
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input int hold,
                               output int lat, output logic [31:0] prod);
    operando_a = a;
    operando_b = b;
    iniciar    = 1'b1;
    @(posedge clk); #1;
    operando_a = 16'($urandom);
    operando_b = 16'($urandom);
    if (hold <= 1) iniciar = 1'b0;
    checkOutput("terminado_cleared_on_start", {63'd0, terminado}, 64'd0);
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e >= hold - 1) iniciar = 1'b0;
      if (terminado) begin
        lat = e;
        break;
      end
    end
    iniciar = 1'b0;
    prod    = producto;
  endtask

  task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b, input int hold);
    int          lat;
    logic [31:0] prod;
    logic [31:0] expProd;
    applyStimulus(a, b, hold, lat, prod);
    expProd = 32'(a) * 32'(b);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(refLatency(b)));
    checkOutput({tag, "_producto"}, {32'd0, prod}, {32'd0, expProd});
  endtask

  initial begin
    logic [31:0] held;
    int          gap;
    rst_n      = 1'b0;
    iniciar    = 1'b0;
    operando_a = '0;
    operando_b = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_producto", {32'd0, producto}, 64'd0);
    checkOutput("reset_terminado", {63'd0, terminado}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_producto", {32'd0, producto}, 64'd0);
    checkOutput("idle_terminado", {63'd0, terminado}, 64'd0);

    runOp("mul_55x33", 16'h0055, 16'h0033, 1);
    checkOutput("mul_55x33_const", {32'd0, producto}, 64'h0000_10EF);
    held = producto;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("hold_producto", {32'd0, producto}, {32'd0, held});
    checkOutput("hold_terminado", {63'd0, terminado}, 64'd1);

    runOp("mul_max", 16'hFFFF, 16'hFFFF, 1);
    checkOutput("mul_max_const", {32'd0, producto}, 64'hFFFE_0001);
    runOp("mul_b_zero", 16'h1234, 16'h0000, 1);
    runOp("mul_a_zero", 16'h0000, 16'hBEEF, 1);

    // Start held high for three edges must launch a single operation only
    runOp("held_start", 16'h0F0F, 16'h8001, 3);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("held_start_stays_done", {63'd0, terminado}, 64'd1);

    operando_a = 16'h00FF;
    operando_b = 16'h00FF;
    iniciar    = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_producto", {32'd0, producto}, 64'd0);
    checkOutput("abort_terminado", {63'd0, terminado}, 64'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_idle_terminado", {63'd0, terminado}, 64'd0);
    checkOutput("abort_idle_producto", {32'd0, producto}, 64'd0);
    runOp("mul_3x7", 16'd3, 16'd7, 1);

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'd0;
        1: rb = 16'($urandom_range(0, 15));
        2: ra = 16'hFFFF;
        default: ;
      endcase
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      #1;
      runOp("random", ra, rb, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
